// File: rtl/elc3_io_pkg.sv
`default_nettype none
// ============================================================================
// Package : elc3_io_pkg
// Brief   : Shared constants and types for the eLC-3 memory-mapped I/O block.
// Rev     : 1.0  initial release
// ============================================================================
package elc3_io_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [6:0]  IO_PAGE   = 7'h7F;
    localparam logic [15:0] MCR_RESET = 16'h8000;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } io_state_t;

    function automatic logic in_io_page(input logic [15:0] addr);
        return (addr[15:9] == IO_PAGE);
    endfunction

endpackage : elc3_io_pkg
`default_nettype wire

// File: rtl/elc3_io_fifo.sv
`default_nettype none
// ============================================================================
// Module  : elc3_io_fifo
// Brief   : Synchronous FIFO of 16-bit entries feeding the display driver.
// Rev     : 1.0  initial release
// ============================================================================
module elc3_io_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic        pop,
    output logic [15:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule : elc3_io_fifo
`default_nettype wire

// File: rtl/elc3_io_ctl.sv
`default_nettype none
// ============================================================================
// Module  : elc3_io_ctl
// Brief   : eLC-3 I/O page controller (KBSR/KBDR/DSR/DDR/MCR, display FIFO).
//           Define ELC3_IO_IRQ_EN to enable the KBSR IE bit and Kbd_Irq.
// Rev     : 1.0  initial release
// ============================================================================
module elc3_io_ctl
    import elc3_io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] Addr,
    input  logic [15:0] Wr_Data,
    output logic        IO_Sel,
    output logic [15:0] Rd_Data,
    output logic        IO_Ready,
    input  logic [15:0] Kbd_Data,
    input  logic        Key_Strobe,
    output logic [15:0] Disp_Data,
    output logic        Disp_Valid,
    input  logic        Disp_Ack,
    output logic        Run_En,
    output logic        Kbd_Irq
);

    io_state_t              state_q, state_d;
    logic                   access;
    logic                   rd_acc;
    logic                   wr_acc;
    logic [15:0]            rd_mux;
    logic [15:0]            rd_data_q, rd_data_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   key_prev_q;
    logic                   key_evt;
    logic [15:0]            kbdr_q, kbdr_d;
    logic                   kbsr_rdy_q, kbsr_rdy_d;
    logic                   kbsr_ie;
    logic [15:0]            mcr_q, mcr_d;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign IO_Sel = MIO_EN && in_io_page(Addr);

    // Access FSM: one access per IDLE->ACK transition; ACK always returns to IDLE.
    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (IO_Sel) begin
                    state_d = ACK;
                    access  = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_acc   = access && !R_W;
    assign wr_acc   = access && R_W;
    assign IO_Ready = (state_q == ACK);
    assign Rd_Data  = rd_data_q;

    always_comb begin
        rd_mux = 16'h0000;
        case (Addr)
            KBSR_ADDR: rd_mux = {kbsr_rdy_q, kbsr_ie, 14'b0};
            KBDR_ADDR: rd_mux = kbdr_q;
            DSR_ADDR:  rd_mux = {~fifo_full, 15'b0};
            MCR_ADDR:  rd_mux = mcr_q;
            default:   rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            rd_data_d = rd_mux;
        end else if (wr_acc) begin
            rd_data_d = 16'h0000;
        end
    end

    // Key strobe synchroniser; the cast keeps the low bits so one stage also works.
    assign sync_d  = SYNC_STAGES'({sync_q, Key_Strobe});
    assign key_evt = sync_q[SYNC_STAGES-1] && !key_prev_q;

    // A key arriving alongside a KBDR read wins over the read's ready-clear.
    always_comb begin
        kbdr_d     = kbdr_q;
        kbsr_rdy_d = kbsr_rdy_q;
        if (rd_acc && (Addr == KBDR_ADDR)) begin
            kbsr_rdy_d = 1'b0;
        end
        if (key_evt) begin
            kbdr_d     = Kbd_Data;
            kbsr_rdy_d = 1'b1;
        end
    end

    // Run_En is sticky-low: a write can clear MCR[15] but never set it again.
    always_comb begin
        mcr_d = mcr_q;
        if (wr_acc && (Addr == MCR_ADDR)) begin
            mcr_d     = Wr_Data;
            mcr_d[15] = Wr_Data[15] && mcr_q[15];
        end
    end

    assign Run_En    = mcr_q[15];
    assign fifo_push = wr_acc && (Addr == DDR_ADDR);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            rd_data_q  <= 16'h0000;
            sync_q     <= '0;
            key_prev_q <= 1'b0;
            kbdr_q     <= 16'h0000;
            kbsr_rdy_q <= 1'b0;
            mcr_q      <= MCR_RESET;
        end else begin
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            sync_q     <= sync_d;
            key_prev_q <= sync_q[SYNC_STAGES-1];
            kbdr_q     <= kbdr_d;
            kbsr_rdy_q <= kbsr_rdy_d;
            mcr_q      <= mcr_d;
        end
    end

`ifdef ELC3_IO_IRQ_EN
    logic kbsr_ie_q, kbsr_ie_d;
    logic kbd_irq_q, kbd_irq_d;

    always_comb begin
        kbsr_ie_d = kbsr_ie_q;
        if (wr_acc && (Addr == KBSR_ADDR)) begin
            kbsr_ie_d = Wr_Data[14];
        end
        kbd_irq_d = kbsr_rdy_q && kbsr_ie_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            kbsr_ie_q <= 1'b0;
            kbd_irq_q <= 1'b0;
        end else begin
            kbsr_ie_q <= kbsr_ie_d;
            kbd_irq_q <= kbd_irq_d;
        end
    end

    assign kbsr_ie = kbsr_ie_q;
    assign Kbd_Irq = kbd_irq_q;
`else
    assign kbsr_ie = 1'b0;
    assign Kbd_Irq = 1'b0;
`endif

    elc3_io_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (fifo_push),
        .wdata (Wr_Data),
        .pop   (Disp_Ack),
        .rdata (Disp_Data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign Disp_Valid = !fifo_empty;

endmodule : elc3_io_ctl
`default_nettype wire

// File: tb/tb_elc3_io_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_elc3_io_ctl
// Brief   : Directed self-checking bench for elc3_io_ctl (FIFO_DEPTH=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_elc3_io_ctl;

    logic        Clk;
    logic        Reset;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] Addr;
    logic [15:0] Wr_Data;
    logic        IO_Sel;
    logic [15:0] Rd_Data;
    logic        IO_Ready;
    logic [15:0] Kbd_Data;
    logic        Key_Strobe;
    logic [15:0] Disp_Data;
    logic        Disp_Valid;
    logic        Disp_Ack;
    logic        Run_En;
    logic        Kbd_Irq;

    int checks = 0;
    int errors = 0;

    elc3_io_ctl #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MIO_EN     (MIO_EN),
        .R_W        (R_W),
        .Addr       (Addr),
        .Wr_Data    (Wr_Data),
        .IO_Sel     (IO_Sel),
        .Rd_Data    (Rd_Data),
        .IO_Ready   (IO_Ready),
        .Kbd_Data   (Kbd_Data),
        .Key_Strobe (Key_Strobe),
        .Disp_Data  (Disp_Data),
        .Disp_Valid (Disp_Valid),
        .Disp_Ack   (Disp_Ack),
        .Run_En     (Run_En),
        .Kbd_Irq    (Kbd_Irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One complete bus access: IO_Sel now, IO_Ready one cycle later, then idle.
    task automatic io_access(input logic rw, input logic [15:0] addr,
                             input logic [15:0] wdata, output logic [15:0] rdata);
        MIO_EN  = 1'b1;
        R_W     = rw;
        Addr    = addr;
        Wr_Data = wdata;
        #1;
        check("io_sel", {15'b0, IO_Sel}, 16'h0001);
        tick();
        check("io_ready", {15'b0, IO_Ready}, 16'h0001);
        rdata  = Rd_Data;
        MIO_EN = 1'b0;
        R_W    = 1'b0;
        tick();
        check("io_ready_drop", {15'b0, IO_Ready}, 16'h0000);
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        io_access(1'b0, addr, 16'h0000, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        logic [15:0] d;
        io_access(1'b1, addr, data, d);
        check("wr_rdata", d, 16'h0000);
    endtask

    task automatic key_press(input logic [15:0] data);
        Kbd_Data   = data;
        Key_Strobe = 1'b1;
        repeat (4) tick();
        Key_Strobe = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        Reset      = 1'b1;
        MIO_EN     = 1'b0;
        R_W        = 1'b0;
        Addr       = 16'h0000;
        Wr_Data    = 16'h0000;
        Kbd_Data   = 16'h0000;
        Key_Strobe = 1'b0;
        Disp_Ack   = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;

        // Reset state
        check("rst_io_ready", {15'b0, IO_Ready}, 16'h0000);
        check("rst_rd_data", Rd_Data, 16'h0000);
        repeat (3) tick();
        check("rst_run_en", {15'b0, Run_En}, 16'h0001);
        check("rst_disp_valid", {15'b0, Disp_Valid}, 16'h0000);
        check("rst_kbd_irq", {15'b0, Kbd_Irq}, 16'h0000);
        rd("rst_kbsr", 16'hFE00, 16'h0000);

        // Decode: outside the page, unmapped read, ignored write
        MIO_EN = 1'b1;
        Addr   = 16'h3000;
        #1;
        check("io_sel_low_mem", {15'b0, IO_Sel}, 16'h0000);
        MIO_EN = 1'b0;
        Addr   = 16'hFE00;
        #1;
        check("io_sel_no_en", {15'b0, IO_Sel}, 16'h0000);
        tick();
        rd("unmapped_rd", 16'hFE08, 16'h0000);
        wr(16'hFE10, 16'hFFFF);
        rd("mcr_after_unmapped_wr", 16'hFFFE, 16'h8000);

        // Key input path
        key_press(16'h0041);
        rd("kbsr_ready", 16'hFE00, 16'h8000);
        rd("kbdr_data", 16'hFE02, 16'h0041);
        rd("kbsr_cleared", 16'hFE00, 16'h0000);

        // Display FIFO fill to full, drop on overflow, drain in order
        wr(16'hFE06, 16'h0048);
        check("disp_head_first", Disp_Data, 16'h0048);
        wr(16'hFE06, 16'h0069);
        wr(16'hFE06, 16'h0021);
        wr(16'hFE06, 16'h0021);
        rd("dsr_full", 16'hFE04, 16'h0000);
        wr(16'hFE06, 16'h0058);
        rd("ddr_read", 16'hFE06, 16'h0000);
        Disp_Ack = 1'b1;
        check("drain0", Disp_Data, 16'h0048);
        tick();
        check("drain1", Disp_Data, 16'h0069);
        tick();
        check("drain2", Disp_Data, 16'h0021);
        tick();
        check("drain3", Disp_Data, 16'h0021);
        check("drain3_valid", {15'b0, Disp_Valid}, 16'h0001);
        tick();
        check("drain_empty", {15'b0, Disp_Valid}, 16'h0000);
        Disp_Ack = 1'b0;
        rd("dsr_not_full", 16'hFE04, 16'h8000);

        // Push while empty with Ack high: value stays, count 1
        MIO_EN   = 1'b1;
        R_W      = 1'b1;
        Addr     = 16'hFE06;
        Wr_Data  = 16'h0055;
        Disp_Ack = 1'b1;
        tick();
        Disp_Ack = 1'b0;
        MIO_EN   = 1'b0;
        R_W      = 1'b0;
        check("push_pop_empty_valid", {15'b0, Disp_Valid}, 16'h0001);
        check("push_pop_empty_data", Disp_Data, 16'h0055);
        tick();
        Disp_Ack = 1'b1;
        tick();
        Disp_Ack = 1'b0;
        check("push_pop_empty_one", {15'b0, Disp_Valid}, 16'h0000);

        // Push and pop together while full: count stays 4
        wr(16'hFE06, 16'h0001);
        wr(16'hFE06, 16'h0002);
        wr(16'hFE06, 16'h0003);
        wr(16'hFE06, 16'h0004);
        MIO_EN   = 1'b1;
        R_W      = 1'b1;
        Addr     = 16'hFE06;
        Wr_Data  = 16'h0005;
        Disp_Ack = 1'b1;
        tick();
        Disp_Ack = 1'b0;
        MIO_EN   = 1'b0;
        R_W      = 1'b0;
        check("full_pp_head", Disp_Data, 16'h0002);
        tick();
        rd("full_pp_dsr", 16'hFE04, 16'h0000);
        Disp_Ack = 1'b1;
        tick();
        tick();
        tick();
        check("full_pp_last", Disp_Data, 16'h0005);
        tick();
        Disp_Ack = 1'b0;
        check("full_pp_empty", {15'b0, Disp_Valid}, 16'h0000);

        // Key event coincident with KBDR read: new key wins
        key_press(16'h0043);
        Kbd_Data   = 16'h0042;
        Key_Strobe = 1'b1;
        tick();
        tick();
        rd("kbdr_old_on_collide", 16'hFE02, 16'h0043);
        Key_Strobe = 1'b0;
        tick();
        rd("kbsr_after_collide", 16'hFE00, 16'h8000);
        rd("kbdr_after_collide", 16'hFE02, 16'h0042);
        rd("kbsr_after_collide_rd", 16'hFE00, 16'h0000);

        // MCR: Run_En clears and stays cleared until Reset
        wr(16'hFE06, 16'h0077);
        wr(16'hFFFE, 16'h0000);
        check("run_en_cleared", {15'b0, Run_En}, 16'h0000);
        wr(16'hFFFE, 16'h8000);
        check("run_en_sticky", {15'b0, Run_En}, 16'h0000);
        rd("mcr_read", 16'hFFFE, 16'h0000);

        // Reset during ACK
        MIO_EN = 1'b1;
        R_W    = 1'b0;
        Addr   = 16'hFE00;
        tick();
        check("ack_before_reset", {15'b0, IO_Ready}, 16'h0001);
        MIO_EN = 1'b0;
        Reset  = 1'b1;
        tick();
        Reset = 1'b0;
        check("reset_mid_ready", {15'b0, IO_Ready}, 16'h0000);
        check("reset_run_en", {15'b0, Run_En}, 16'h0001);
        check("reset_fifo_flushed", {15'b0, Disp_Valid}, 16'h0000);
        tick();

        // Interrupt enable
        wr(16'hFE00, 16'h4000);
`ifdef ELC3_IO_IRQ_EN
        rd("kbsr_ie_readback", 16'hFE00, 16'h4000);
        key_press(16'h0044);
        check("irq_asserted", {15'b0, Kbd_Irq}, 16'h0001);
        rd("kbdr_irq_key", 16'hFE02, 16'h0044);
        check("irq_cleared", {15'b0, Kbd_Irq}, 16'h0000);
`else
        rd("kbsr_ie_readback", 16'hFE00, 16'h0000);
        key_press(16'h0044);
        check("irq_tied_low", {15'b0, Kbd_Irq}, 16'h0000);
        rd("kbdr_irq_key", 16'hFE02, 16'h0044);
        check("irq_still_low", {15'b0, Kbd_Irq}, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_elc3_io_ctl
`default_nettype wire
